shift_add_mul_sched: RTL and testbench
======================================

// Module: shift_add_mul_sched
// PURPOSE
// - Shares one serial shift-add multiply datapath between REQ requesters.
// - Arbitrates operand requests round-robin, sequences one bit per cycle for N cycles,
//   then returns a 2N-bit product tagged with the requester index.
// - Sits between client blocks (valid/ready request ports) and the serial multiplier core.
// PARAMETERS
// - N    8  operand width in bits; product is 2N bits
// - REQ  2  number of requesters (>=2); ID width IDW = $clog2(REQ)
// PORTS
// - clk          in   1        single clock; all state changes on posedge clk
// - rst          in   1        synchronous, active-high reset
// - req_valid    in   REQ      per-requester operand valid
// - req_ready    out  REQ      per-requester accept; at most one bit high
// - req_a        in   REQ*N    multiplicands, requester i at [i*N +: N]
// - req_b        in   REQ*N    multipliers, requester i at [i*N +: N]
// - res_valid    out  1        product valid; held until res_ready
// - res_ready    in   1        consumer accepts product
// - res_id       out  IDW      index of the requester that owns res_product
// - res_product  out  2N       a*b, unsigned
// - busy         out  1        high in RUN and DONE
// BEHAVIOUR
// - Reset: state=IDLE, req_ready=0, res_valid=0, res_id=0, res_product=0, busy=0.
//   rr_ptr=REQ-1, so requester 0 has first priority.
// - Reset asserted mid-RUN or mid-DONE aborts the operation; no result is ever presented.
// - FSM states and transitions:
//   - IDLE: if any req_valid, pick grant g = first i with req_valid[i], searching from
//     rr_ptr+1 mod REQ upward with wrap. req_ready[g]=1 (combinational, IDLE only).
//     On that edge: latch a=req_a[g], b=req_b[g], id=g, rr_ptr=g, acc=0, cnt=0; -> RUN.
//     With no req_valid: stay IDLE, all req_ready=0.
//   - RUN: each cycle, if b[cnt] then acc += {N'b0,a} << cnt; cnt++.
//     After the cycle with cnt==N-1: res_product=acc (final), res_valid=1; -> DONE.
//     Takes exactly N cycles.
//   - DONE: hold res_valid/res_id/res_product stable. On res_valid&&res_ready:
//     res_valid=0; -> IDLE.
// - Latency: request handshake at edge E; res_valid first high after edge E+N.
// - Throughput: min N+2 cycles per op (1 IDLE grant, N RUN, 1 DONE handshake).
// - Busy blocking: no req_ready in RUN or DONE. A res_ready held low stalls in DONE indefinitely.
// - req_valid may drop before grant; only the sampled IDLE cycle matters. No fairness
//   credit is kept for dropped requests.
// - Arithmetic: unsigned; acc is 2N bits and never overflows. Operand 0 gives product 0
//   after the full N cycles (no early exit).
// - res_product and res_id are unchanged after leaving DONE until the next result.
// STRUCTURE
// - Package shift_add_mul_pkg: state enum localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
//   and a clog2-based IDW helper.
// - Sub-module rr_arbiter #(REQ): combinational grant from req_valid and rr_ptr, output
//   one-hot plus index. The FSM, counter and accumulator stay in this module.
// TESTING
// - Reset, then req0: a=8'd13, b=8'd11 -> res_valid 8 cycles after the accept edge;
//   res_product=16'd143, res_id=0.
// - Corner values a=8'hFF, b=8'hFF -> 16'hFE01; a=0, b=8'hA5 -> 0, still after 8 RUN cycles.
// - req0 and req1 both held valid with res_ready=1 -> grants alternate 0,1,0,1;
//   each requester's operands paired with its own res_id.
// - res_ready low for 20 cycles in DONE -> res_valid and product stable; req_ready stays 0.
//   res_ready high -> IDLE next cycle.
// - rst pulsed at RUN cycle 4 -> next cycle IDLE, res_valid=0, no result.
//   Next grant goes to requester 0.
// - req1 valid alone after req1 served last -> req1 granted again (wrap search, no starvation).

Source files
------------

// File: rtl/shift_add_mul_pkg.sv
// Shared types and helpers for the shift-add multiply scheduler.
package shift_add_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Index width for n items; never below one bit so ports stay legal.
   function automatic int unsigned idw_of(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/shift_add_mul_sched_rr_arbiter.sv
// Round-robin grant: first valid requester strictly after rr_ptr, with wrap.
module rr_arbiter
   import shift_add_mul_pkg::*;
#(
   parameter int unsigned REQ = 2,
   localparam int unsigned IDW = idw_of(REQ)
) (
   input  logic [REQ-1:0] req_valid,
   input  logic [IDW-1:0] rr_ptr,
   output logic [REQ-1:0] grant,
   output logic [IDW-1:0] grant_idx,
   output logic           grant_valid
);

   // Search above the pointer first, then fall back to the lowest index (wrap).
   always_comb begin
      grant_idx   = '0;
      grant_valid = 1'b0;
      grant       = '0;
      for (int unsigned i = 0; i < REQ; i++) begin
         if (!grant_valid && req_valid[i] && (i > 32'(rr_ptr))) begin
            grant_valid = 1'b1;
            grant_idx   = IDW'(i);
         end
      end
      for (int unsigned i = 0; i < REQ; i++) begin
         if (!grant_valid && req_valid[i]) begin
            grant_valid = 1'b1;
            grant_idx   = IDW'(i);
         end
      end
      if (grant_valid) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/shift_add_mul_sched.sv
// Serial shift-add multiplier shared by REQ requesters via round-robin grant.
module shift_add_mul_sched
   import shift_add_mul_pkg::*;
#(
   parameter int unsigned N   = 8,
   parameter int unsigned REQ = 2,
   localparam int unsigned IDW = idw_of(REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [REQ-1:0]     req_valid,
   output logic [REQ-1:0]     req_ready,
   input  logic [REQ*N-1:0]   req_a,
   input  logic [REQ*N-1:0]   req_b,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [IDW-1:0]     res_id,
   output logic [2*N-1:0]     res_product,
   output logic               busy
);

   localparam int unsigned CW = idw_of(N);

   state_t           state;
   logic [N-1:0]     a_q;
   logic [N-1:0]     b_q;
   logic [IDW-1:0]   id_q;
   logic [CW-1:0]    cnt;
   logic [2*N-1:0]   acc;
   logic [2*N-1:0]   addend;
   logic [2*N-1:0]   acc_next;
   logic [IDW-1:0]   rr_ptr;
   logic [REQ-1:0]   grant;
   logic [IDW-1:0]   grant_idx;
   logic             grant_valid;
   logic [N-1:0]     sel_a;
   logic [N-1:0]     sel_b;

   rr_arbiter #(.REQ(REQ)) u_arb (
      .req_valid   (req_valid),
      .rr_ptr      (rr_ptr),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   // Operand mux for the granted requester and the per-bit partial product.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int unsigned i = 0; i < REQ; i++) begin
         if (grant[i]) begin
            sel_a = req_a[i*N +: N];
            sel_b = req_b[i*N +: N];
         end
      end
      addend   = b_q[cnt] ? ({{N{1'b0}}, a_q} << cnt) : '0;
      acc_next = acc + addend;
   end

   assign req_ready = (state == IDLE) ? grant : '0;
   assign busy      = (state != IDLE);

   // Control FSM: grant in IDLE, N accumulate cycles in RUN, hold result in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         res_valid   <= 1'b0;
         res_id      <= '0;
         res_product <= '0;
         rr_ptr      <= IDW'(REQ - 1);
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= '0;
         acc         <= '0;
         cnt         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  a_q    <= sel_a;
                  b_q    <= sel_b;
                  id_q   <= grant_idx;
                  rr_ptr <= grant_idx;
                  acc    <= '0;
                  cnt    <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               acc <= acc_next;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(N - 1)) begin
                  res_product <= acc_next;
                  res_id      <= id_q;
                  res_valid   <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_mul_sched.sv
// Self-checking bench for shift_add_mul_sched with a behavioural reference model.
module tb_shift_add_mul_sched;

   localparam int unsigned N   = 8;
   localparam int unsigned REQ = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [REQ-1:0]    req_valid;
   logic [REQ-1:0]    req_ready;
   logic [REQ*N-1:0]  req_a;
   logic [REQ*N-1:0]  req_b;
   logic              res_valid;
   logic              res_ready;
   logic [0:0]        res_id;
   logic [2*N-1:0]    res_product;
   logic              busy;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned m_ptr    = REQ - 1;

   shift_add_mul_sched #(.N(N), .REQ(REQ)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_id      (res_id),
      .res_product (res_product),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   // Round-robin reference: first valid index after the last winner, modulo REQ.
   function automatic int unsigned model_grant(input logic [REQ-1:0] v);
      for (int unsigned k = 1; k <= REQ; k++) begin
         int unsigned i;
         i = (m_ptr + k) % REQ;
         if (v[i]) return i;
      end
      return 0;
   endfunction

   // One full transaction from IDLE; leaves the DUT in IDLE, 1ns after an edge.
   task automatic run_op(input logic [REQ-1:0] v,
                         input logic [7:0] a0, input logic [7:0] b0,
                         input logic [7:0] a1, input logic [7:0] b1,
                         input int unsigned stall);
      int unsigned g;
      logic [15:0] expp;
      req_valid = v;
      req_a     = {a1, a0};
      req_b     = {b1, b0};
      res_ready = (stall == 0);
      #1;
      if (v == '0) begin
         check("idle_ready", 32'(req_ready), 32'd0);
         @(posedge clk); #1;
         check("idle_busy", 32'(busy), 32'd0);
         return;
      end
      g = model_grant(v);
      check("grant", 32'(req_ready), 32'(1) << g);
      @(posedge clk); #1;
      req_valid = '0;
      m_ptr     = g;
      expp      = (g == 0) ? 16'(a0) * 16'(b0) : 16'(a1) * 16'(b1);
      for (int unsigned k = 0; k < N; k++) begin
         check("run_valid", 32'(res_valid), 32'd0);
         check("run_busy", 32'(busy), 32'd1);
         check("run_ready", 32'(req_ready), 32'd0);
         @(posedge clk); #1;
      end
      check("done_valid", 32'(res_valid), 32'd1);
      check("done_id", 32'(res_id), g);
      check("done_product", 32'(res_product), 32'(expp));
      if (stall > 0) begin
         req_valid = '1;
         for (int unsigned s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(res_valid), 32'd1);
            check("stall_product", 32'(res_product), 32'(expp));
            check("stall_ready", 32'(req_ready), 32'd0);
         end
         req_valid = '0;
         res_ready = 1'b1;
      end
      @(posedge clk); #1;
      check("post_valid", 32'(res_valid), 32'd0);
      check("post_busy", 32'(busy), 32'd0);
      check("post_product", 32'(res_product), 32'(expp));
      check("post_id", 32'(res_id), g);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      res_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(res_valid), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_product", 32'(res_product), 32'd0);
      check("rst_id", 32'(res_id), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;

      // Directed corners
      run_op(2'b01, 8'd13, 8'd11, 8'd0, 8'd0, 0);
      run_op(2'b01, 8'hFF, 8'hFF, 8'd0, 8'd0, 0);
      run_op(2'b01, 8'h00, 8'hA5, 8'd0, 8'd0, 0);
      run_op(2'b00, 8'd1, 8'd1, 8'd1, 8'd1, 0);

      // Both requesters held valid: grants must alternate
      for (int unsigned r = 0; r < 4; r++)
         run_op(2'b11, 8'(r + 3), 8'(r + 7), 8'(r + 100), 8'(r + 50), 0);

      // Long consumer stall
      run_op(2'b10, 8'd200, 8'd3, 8'd77, 8'd9, 20);

      // Requester 1 alone after being served last is granted again
      run_op(2'b10, 8'd1, 8'd1, 8'd5, 8'd6, 0);

      // Reset in the middle of RUN aborts without a result
      req_valid = 2'b10;
      req_a     = {8'd9, 8'd9};
      req_b     = {8'd9, 8'd9};
      @(posedge clk); #1;
      req_valid = '0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      m_ptr = REQ - 1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_valid", 32'(res_valid), 32'd0);
      for (int unsigned k = 0; k < N + 2; k++) begin
         @(posedge clk); #1;
         check("abort_quiet", 32'(res_valid), 32'd0);
      end
      run_op(2'b11, 8'd21, 8'd2, 8'd33, 8'd4, 0);

      // Randomized traffic
      for (int unsigned r = 0; r < 40; r++) begin
         run_op(2'($urandom_range(0, 3)),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
